// File: rtl/simplecpu_ctrl_pkg.sv
// simplecpu_ctrl_pkg
//   Shared definitions for the simplecpu load sequencer: FSM state encoding
//   and the default RAM/counter widths used by simplecpu_load_ctrl.
package simplecpu_ctrl_pkg;

    localparam int unsigned ADDR_W = 4;   // RAM address width (program = 2^ADDR_W words)
    localparam int unsigned DATA_W = 8;   // RAM word width
    localparam int unsigned CNT_W  = 16;  // run_limit / cycle_count width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_HOLD,
        ST_RUN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/simplecpu_load_ctrl_sat_counter.sv
// sat_counter
//   Up-counter with synchronous clear and enable that sticks at all-ones.
//   Ports:
//     i_clk    in   1      rising-edge clock
//     i_rst    in   1      asynchronous active-high reset (count -> 0)
//     i_clr    in   1      synchronous clear, wins over i_en
//     i_en     in   1      count enable
//     o_count  out  WIDTH  current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/simplecpu_load_ctrl.sv
// simplecpu_load_ctrl
//   Sequencer for the simplecpu core: holds the CPU in reset, streams one
//   2^ADDR_W-word program into its RAM, holds reset for RST_HOLD more cycles,
//   then runs the CPU for run_limit cycles (0 = unlimited) or until stop.
//   Ports:
//     clk          in   1       rising-edge clock
//     reset        in   1       asynchronous active-high reset
//     start        in   1       begin a load from IDLE or HALT
//     stop         in   1       abort a load / end a run; wins over start
//     run_limit    in   CNT_W   run budget, latched when entering HOLD
//     wr_valid     in   1       program word present
//     wr_data      in   DATA_W  program word
//     wr_ready     out  1       word accepted this cycle if wr_valid
//     cpu_reset    out  1       simplecpu reset, low only in RUN
//     load_ram     out  1       RAM write strobe
//     load_addr    out  ADDR_W  RAM write address
//     load_data    out  DATA_W  RAM write data
//     busy         out  1       LOAD, FLUSH or HOLD
//     running      out  1       RUN
//     done         out  1       HALT
//     aborted      out  1       last load cut short by stop
//     cycle_count  out  CNT_W   RUN cycles elapsed, saturating
module simplecpu_load_ctrl #(
    parameter int unsigned ADDR_W   = simplecpu_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W   = simplecpu_ctrl_pkg::DATA_W,
    parameter int unsigned CNT_W    = simplecpu_ctrl_pkg::CNT_W,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  run_limit,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              cpu_reset,
    output logic              load_ram,
    output logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              running,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  cycle_count
);

    import simplecpu_ctrl_pkg::*;

    // HOLD counter runs 0..RST_HOLD-1
    localparam int unsigned       HOLD_W    = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_t             r_state;
    state_t             w_next;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_wr_pend;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [CNT_W-1:0]   r_limit;
    logic               r_aborted;

    logic               w_wr_ready;
    logic               w_hs;
    logic               w_last_word;
    logic               w_enter_load;
    logic               w_abort;
    logic               w_hold_clr;
    logic               w_hold_en;
    logic               w_hold_done;
    logic               w_run_en;
    logic               w_limit_hit;
    logic [HOLD_W-1:0]  w_hold_cnt;
    logic [CNT_W-1:0]   w_cycle_cnt;
    logic [CNT_W:0]     w_cycle_inc;

    // stop masks ready so an aborting cycle can never also accept a word
    assign w_wr_ready   = (r_state == ST_LOAD) && !stop;
    assign w_hs         = wr_valid && w_wr_ready;
    assign w_last_word  = w_hs && (r_addr == '1);
    assign w_enter_load = (r_state != ST_LOAD) && (w_next == ST_LOAD);
    assign w_abort      = stop && ((r_state == ST_LOAD) || (r_state == ST_HOLD));

    assign w_hold_clr   = (r_state != ST_HOLD);
    assign w_hold_en    = (r_state == ST_HOLD);
    assign w_hold_done  = (w_hold_cnt == HOLD_LAST);

    assign w_run_en     = (r_state == ST_RUN);
    // one bit wider so a saturated count cannot wrap onto a small limit
    assign w_cycle_inc  = {1'b0, w_cycle_cnt} + (CNT_W + 1)'(1);
    assign w_limit_hit  = (r_limit != '0) && (w_cycle_inc == {1'b0, r_limit});

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (stop)             w_next = ST_IDLE;
                else if (w_last_word) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (stop)             w_next = ST_IDLE;
                else if (w_hold_done) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (stop || w_limit_hit) w_next = ST_HALT;
            end
            ST_HALT: begin
                if (start && !stop) w_next = ST_LOAD;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        wr_ready  = w_wr_ready;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        running   = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_LOAD, ST_FLUSH, ST_HOLD: busy = 1'b1;
            ST_RUN: begin
                cpu_reset = 1'b0;
                running   = 1'b1;
            end
            ST_HALT: done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- address counter, write pipeline, limit, abort flag ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_limit   <= '0;
            r_aborted <= 1'b0;
        end else begin
            if (w_enter_load) begin
                r_addr <= '0;
            end else if (w_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            // strobe one cycle after the handshake; a pending write still
            // issues even if the load is aborted in the same cycle
            r_wr_pend <= w_hs;
            if (w_hs) begin
                r_wr_addr <= r_addr;
                r_wr_data <= wr_data;
            end

            if (r_state == ST_FLUSH) begin
                r_limit <= run_limit;
            end

            if (w_enter_load) begin
                r_aborted <= 1'b0;
            end else if (w_abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_cnt (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_clr   (w_hold_clr),
        .i_en    (w_hold_en),
        .o_count (w_hold_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_clr   (w_enter_load),
        .i_en    (w_run_en),
        .o_count (w_cycle_cnt)
    );

    assign load_ram    = r_wr_pend;
    assign load_addr   = r_wr_addr;
    assign load_data   = r_wr_data;
    assign aborted     = r_aborted;
    assign cycle_count = w_cycle_cnt;

endmodule

// File: tb/tb_simplecpu_load_ctrl.sv
// tb_simplecpu_load_ctrl
//   Directed bench for simplecpu_load_ctrl. Every accepted program word is
//   pushed to a scoreboard and must come back as a load_ram strobe exactly one
//   cycle later with the expected address and data.
module tb_simplecpu_load_ctrl;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] run_limit;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        cpu_reset;
    logic        load_ram;
    logic [3:0]  load_addr;
    logic [7:0]  load_data;
    logic        busy;
    logic        running;
    logic        done;
    logic        aborted;
    logic [15:0] cycle_count;

    wr_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  tb_addr;
    bit          last_hs;
    int          n_strobe;
    int          low;

    always #5 clk = ~clk;

    simplecpu_load_ctrl #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .CNT_W    (16),
        .RST_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .run_limit   (run_limit),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .cpu_reset   (cpu_reset),
        .load_ram    (load_ram),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy),
        .running     (running),
        .done        (done),
        .aborted     (aborted),
        .cycle_count (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a handshake before the edge, check the strobe after it.
    task automatic tick();
        wr_t e;
        bit  hs;
        #1;
        hs = (wr_valid === 1'b1) && (wr_ready === 1'b1);
        if (hs) begin
            sb.push_back({tb_addr, wr_data});
            tb_addr = tb_addr + 4'd1;
        end
        @(posedge clk);
        #1;
        last_hs = hs;
        chk("strobe_timing", 32'(load_ram), 32'(hs));
        if (load_ram === 1'b1) begin
            n_strobe++;
            chk("cpu_reset_during_write", 32'(cpu_reset), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("load_addr", 32'(load_addr), 32'(e.a));
                chk("load_data", 32'(load_data), 32'(e.d));
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_cpu_reset"},   32'(cpu_reset),   32'd1);
        chk({pfx, "_wr_ready"},    32'(wr_ready),    32'd0);
        chk({pfx, "_load_ram"},    32'(load_ram),    32'd0);
        chk({pfx, "_load_addr"},   32'(load_addr),   32'd0);
        chk({pfx, "_load_data"},   32'(load_data),   32'd0);
        chk({pfx, "_busy"},        32'(busy),        32'd0);
        chk({pfx, "_running"},     32'(running),     32'd0);
        chk({pfx, "_done"},        32'(done),        32'd0);
        chk({pfx, "_aborted"},     32'(aborted),     32'd0);
        chk({pfx, "_cycle_count"}, 32'(cycle_count), 32'd0);
    endtask

    // Stream 16 words base..base+15; with gap set, wr_valid toggles each cycle.
    task automatic load_prog(input logic [7:0] base, input bit gap);
        int n;
        n = 0;
        for (int g = 0; g < 200 && n < 16; g++) begin
            wr_valid = gap ? ((g % 2) == 0) : 1'b1;
            wr_data  = base + 8'(n);
            tick();
            if (last_hs) n++;
        end
        wr_valid = 1'b0;
        chk("words_accepted", 32'(n), 32'd16);
        chk("wr_ready_after_load", 32'(wr_ready), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
    endtask

    // From FLUSH: four HOLD cycles with cpu_reset high, then RUN.
    task automatic hold_then_run();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_running", 32'(running), 32'd1);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_first_count", 32'(cycle_count), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        run_limit = 16'd0;
        wr_valid  = 1'b0;
        wr_data   = 8'd0;
        tb_addr   = 4'd0;
        n_strobe  = 0;
        last_hs   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check_reset_outputs("idle");

        // full load with wr_valid held high, bounded run of 100
        run_limit = 16'd100;
        tb_addr   = 4'd0;
        n_strobe  = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_wr_ready", 32'(wr_ready), 32'd1);
        load_prog(8'h10, 1'b0);
        hold_then_run();
        chk("t1_strobes", 32'(n_strobe), 32'd16);

        low = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cpu_reset !== 1'b0) break;
            low++;
        end
        chk("t3_low_cycles", 32'(low), 32'd100);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_count", 32'(cycle_count), 32'd100);
        chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t3_running", 32'(running), 32'd0);

        // reload from HALT with backpressure, unbounded run
        run_limit = 16'd0;
        tb_addr   = 4'd0;
        n_strobe  = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_count_cleared", 32'(cycle_count), 32'd0);
        chk("t2_done_cleared", 32'(done), 32'd0);
        load_prog(8'hA0, 1'b1);
        hold_then_run();
        chk("t2_strobes", 32'(n_strobe), 32'd16);

        repeat (70000) tick();
        chk("t4_running", 32'(running), 32'd1);
        chk("t4_saturated", 32'(cycle_count), 32'hFFFF);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_running_off", 32'(running), 32'd0);
        chk("t4_cpu_reset_hi", 32'(cpu_reset), 32'd1);
        tick();
        chk("t4_count_held", 32'(cycle_count), 32'hFFFF);
        chk("t4_done_held", 32'(done), 32'd1);

        // abort after word 5
        tb_addr  = 4'd0;
        n_strobe = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h30 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        stop     = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_aborted", 32'(aborted), 32'd1);
        chk("t5_wr_ready", 32'(wr_ready), 32'd0);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        wr_valid = 1'b1;
        repeat (3) tick();
        wr_valid = 1'b0;
        chk("t5_strobes", 32'(n_strobe), 32'd6);
        start = 1'b1;
        stop  = 1'b1;
        repeat (2) tick();
        chk("t5_startstop_busy", 32'(busy), 32'd0);
        chk("t5_startstop_ready", 32'(wr_ready), 32'd0);
        chk("t5_still_aborted", 32'(aborted), 32'd1);
        start = 1'b0;
        stop  = 1'b0;

        // async reset mid-RUN
        tb_addr = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_aborted_cleared", 32'(aborted), 32'd0);
        load_prog(8'h50, 1'b0);
        hold_then_run();
        repeat (5) tick();
        chk("t6_count", 32'(cycle_count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        sb.delete();
        #3;
        reset = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
